// File: rtl/VX_tcu_pkg.sv
// TCU shared definitions.
//   TCU_MAX_INPUTS       : width of the per-lane valid mask fed to the FEDP
//   tcu_fedp_seq_state_t : control states of the FEDP sequencer
package VX_tcu_pkg;

  localparam int TCU_MAX_INPUTS = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_RESP  = 2'd3
  } tcu_fedp_seq_state_t;

endpackage

// File: rtl/vx_tcu_fedp_seq.sv
// FEDP sequencer. Takes one dot-product request of up to KMAX N-wide
// operand slices and issues each slice to a fused dot-product unit. Each
// result is chained in as the accumulator of the next slice. The final value
// is returned on a valid/ready response port.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   req_*                            request handshake, tag, formats,
//                                    slice count, initial accumulator
//   opd_*                            operand slice handshake, a/b slices,
//                                    lane mask
//   fedp_*                           FEDP drive (enable, mask, formats,
//                                    operands, accumulator) and result
//   rsp_*                            response handshake, tag, final value
module vx_tcu_fedp_seq
  import VX_tcu_pkg::*;
#(
  parameter int N       = 2,
  parameter int KMAX    = 8,
  parameter int LATENCY = 4,
  parameter int IDW     = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,

  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [IDW-1:0]                req_tag,
  input  logic [3:0]                    req_fmt_s,
  input  logic [3:0]                    req_fmt_d,
  input  logic [$clog2(KMAX+1)-1:0]     req_nslices,
  input  logic [31:0]                   req_c_val,

  input  logic                          opd_valid,
  output logic                          opd_ready,
  input  logic [N*32-1:0]               opd_a,
  input  logic [N*32-1:0]               opd_b,
  input  logic [TCU_MAX_INPUTS-1:0]     opd_mask,

  output logic                          fedp_enable,
  output logic [TCU_MAX_INPUTS-1:0]     fedp_vld_mask,
  output logic [3:0]                    fedp_fmt_s,
  output logic [3:0]                    fedp_fmt_d,
  output logic [N*32-1:0]               fedp_a_row,
  output logic [N*32-1:0]               fedp_b_col,
  output logic [31:0]                   fedp_c_val,
  input  logic [31:0]                   fedp_d_val,

  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_tag,
  output logic [31:0]                   rsp_d_val
);

  localparam int SCW = $clog2(KMAX + 1);
  localparam int LCW = $clog2(LATENCY + 1);

  tcu_fedp_seq_state_t r_state;
  tcu_fedp_seq_state_t w_state_next;

  logic [IDW-1:0]            r_tag;
  logic [3:0]                r_fmt_s;
  logic [3:0]                r_fmt_d;
  logic [SCW-1:0]            r_nslices;
  logic [SCW-1:0]            r_slice_cnt;
  logic [LCW-1:0]            r_lat_cnt;
  logic [31:0]               r_acc;
  logic                      r_enable;
  logic [N*32-1:0]           r_a_row;
  logic [N*32-1:0]           r_b_col;
  logic [31:0]               r_c_val;
  logic [TCU_MAX_INPUTS-1:0] r_vld_mask;

  logic           w_req_fire;
  logic           w_opd_fire;
  logic           w_opd_live;
  logic [SCW-1:0] w_slice_inc;
  logic           w_last;
  logic           w_d_valid;

  assign w_req_fire  = req_valid & req_ready;
  assign w_opd_fire  = opd_valid & opd_ready;
  assign w_opd_live  = |opd_mask;
  assign w_slice_inc = r_slice_cnt + SCW'(1);
  assign w_last      = (w_slice_inc == r_nslices);
  // lat_cnt is loaded with LATENCY on issue and reaches zero in the cycle
  // the FEDP result for that slice is on fedp_d_val.
  assign w_d_valid   = (r_state == SEQ_WAIT) && (r_lat_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEQ_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SEQ_IDLE: begin
        if (w_req_fire) begin
          w_state_next = (req_nslices == '0) ? SEQ_RESP : SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        if (w_opd_fire) begin
          if (w_opd_live) begin
            w_state_next = SEQ_WAIT;
          end else if (w_last) begin
            w_state_next = SEQ_RESP;
          end
        end
      end
      SEQ_WAIT: begin
        if (w_d_valid) begin
          w_state_next = w_last ? SEQ_RESP : SEQ_ISSUE;
        end
      end
      SEQ_RESP: begin
        if (rsp_ready) begin
          w_state_next = SEQ_IDLE;
        end
      end
      default: w_state_next = SEQ_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == SEQ_IDLE) && r_enable;
    opd_ready = (r_state == SEQ_ISSUE);
    rsp_valid = (r_state == SEQ_RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag       <= '0;
      r_fmt_s     <= '0;
      r_fmt_d     <= '0;
      r_nslices   <= '0;
      r_slice_cnt <= '0;
      r_lat_cnt   <= '0;
      r_acc       <= '0;
      r_enable    <= 1'b0;
      r_a_row     <= '0;
      r_b_col     <= '0;
      r_c_val     <= '0;
      r_vld_mask  <= '0;
    end else begin
      r_enable   <= 1'b1;
      // Mask is only nonzero in the single cycle a slice is presented.
      r_vld_mask <= '0;
      case (r_state)
        SEQ_IDLE: begin
          if (w_req_fire) begin
            r_tag       <= req_tag;
            r_fmt_s     <= req_fmt_s;
            r_fmt_d     <= req_fmt_d;
            r_nslices   <= req_nslices;
            r_acc       <= req_c_val;
            r_slice_cnt <= '0;
          end
        end
        SEQ_ISSUE: begin
          if (w_opd_fire) begin
            if (w_opd_live) begin
              r_a_row    <= opd_a;
              r_b_col    <= opd_b;
              r_vld_mask <= opd_mask;
              r_c_val    <= r_acc;
              r_lat_cnt  <= LCW'(LATENCY);
            end else begin
              r_slice_cnt <= w_slice_inc;
            end
          end
        end
        SEQ_WAIT: begin
          if (r_lat_cnt != '0) begin
            r_lat_cnt <= r_lat_cnt - LCW'(1);
          end else begin
            r_acc       <= fedp_d_val;
            r_slice_cnt <= w_slice_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign fedp_enable   = r_enable;
  assign fedp_vld_mask = r_vld_mask;
  assign fedp_fmt_s    = r_fmt_s;
  assign fedp_fmt_d    = r_fmt_d;
  assign fedp_a_row    = r_a_row;
  assign fedp_b_col    = r_b_col;
  assign fedp_c_val    = r_c_val;
  assign rsp_tag       = r_tag;
  assign rsp_d_val     = r_acc;

endmodule

// File: doc/vx_tcu_fedp_seq.md
# VX_tcu_fedp_seq

Sequencer that drives the TCU fused dot-product (FEDP) unit as its initiator. It accepts one dot-product request of up to KMAX N-wide operand slices and issues each slice to the FEDP. Each FEDP result `d_val` is fed back as the `c_val` of the next slice. The final accumulated value is returned on a valid/ready response port. It sits between the TCU operand-fetch logic and one FEDP instance.

## Interface
- N, 2, operand words per slice (must equal the FEDP's N)
- KMAX, 8, maximum slices per request
- LATENCY, 4, FEDP pipeline latency in cycles (≥1)
- IDW, 4, request tag width
- clk  in  1  clock
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid / req_ready  in/out  1  request handshake
- req_tag  in  IDW  echoed on response
- req_fmt_s, req_fmt_d  in  4  formats forwarded to FEDP
- req_nslices  in  $clog2(KMAX+1)  slice count, 0..KMAX
- req_c_val  in  32  initial accumulator
- opd_valid / opd_ready  in/out  1  operand slice handshake
- opd_a, opd_b  in  N×32  row/column slice
- opd_mask  in  TCU_MAX_INPUTS  lane valid mask
- fedp_enable  out  1  FEDP enable
- fedp_vld_mask  out  TCU_MAX_INPUTS  FEDP vld_mask
- fedp_fmt_s, fedp_fmt_d  out  4  FEDP formats
- fedp_a_row, fedp_b_col  out  N×32  FEDP operands
- fedp_c_val  out  32  FEDP accumulator input
- fedp_d_val  in  32  FEDP result
- rsp_valid / rsp_ready  out/in  1  response handshake
- rsp_tag  out  IDW  tag
- rsp_d_val  out  32  final result

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** `req_ready = fedp_enable`.
  - On req fire, latch tag, fmt, nslices, and `acc = req_c_val`, and clear `slice_cnt`.
  - If nslices == 0, go to RESP. Otherwise go to ISSUE.
- **ISSUE:** `opd_ready = 1`.
  - On opd fire with `opd_mask != 0`: register `fedp_a_row/b_col/vld_mask = opd_*` and `fedp_c_val = acc` for exactly one cycle, load `lat_cnt = LATENCY`, and go to WAIT.
  - On opd fire with `opd_mask == 0`: the slice is skipped. Do not issue to the FEDP, leave `acc` unchanged, increment `slice_cnt`, and go to RESP if `slice_cnt` reaches nslices.
- **WAIT:** decrement `lat_cnt` each cycle.
  - In the cycle `fedp_d_val` is valid, set `acc <= fedp_d_val` and increment `slice_cnt`.
  - Go to RESP if `slice_cnt == nslices`. Otherwise return to ISSUE.
- **RESP:** `rsp_valid = 1`, `rsp_d_val = acc`, `rsp_tag` = latched tag.
  - Outputs are held stable until `rsp_ready`, then go to IDLE.
- One request is in flight at a time. `req_ready` is 0 outside IDLE, and there is no same-cycle rsp→req overlap.
- `fedp_vld_mask` is zero in every cycle except issue cycles. `fedp_fmt_*` holds the latched formats.
- `fedp_enable` is a register: 0 in reset, 1 from the first clk edge after reset release. The FEDP is never stalled; backpressure is absorbed by `acc`.
- The accumulator is opaque 32 bits. Integer and float formats are chained identically.

## Timing
- Reset (async, reset_n low): all outputs are 0, the state is IDLE, and counters are 0. Any FEDP result in flight is discarded.
- Per-slice timing:
  - opd fire in cycle t.
  - FEDP inputs are driven in cycle t+1.
  - `fedp_d_val` is sampled at the end of cycle t+1+LATENCY.
  - The next `opd_ready` is asserted in cycle t+2+LATENCY.
  - Throughput is one slice per LATENCY+2 cycles.
- Last slice fired in cycle t: `rsp_valid` is asserted in cycle t+2+LATENCY.
- nslices == 0: req fire in cycle t gives `rsp_valid` in cycle t+1.
- Skipped final slice fired in cycle t: `rsp_valid` in cycle t+1.

## Structure
- Add `tcu_fedp_seq_state_t` (IDLE/ISSUE/WAIT/RESP) to VX_tcu_pkg. `TCU_MAX_INPUTS` comes from VX_tcu_pkg.
- Single module with no sub-module. The integration wrapper ties the FEDP's active-high reset to `~reset_n`.
- `lat_cnt` width is $clog2(LATENCY+1). `slice_cnt` width is $clog2(KMAX+1).

## Test plan
Bench FEDP stub: `d = c + Σ a[i]*b[i]` (int32 wrap), delayed LATENCY cycles. Parameters N=2, LATENCY=4.
- nslices=1, c=5, a={2,3}, b={4,1}, mask all-ones, opd fire in cycle 0 → `rsp_valid` in cycle 6, d=16, tag echoed.
- nslices=3, c=0, slices ({1,1},{1,2}), ({2,2},{3,3}), ({0,5},{0,9}) → `fedp_c_val` issued as 0, 3, 15; d=60.
- nslices=0, c=0xDEADBEEF → `rsp_valid` one cycle after req fire, d=0xDEADBEEF, `fedp_vld_mask` never nonzero.
- nslices=2, first slice mask=0, second slice a={7,0}, b={6,0}, c=1 → exactly one FEDP issue, d=43.
- `rsp_ready` held low for 10 cycles → rsp data and tag stable, `req_ready`=0. After fire → IDLE, and the next request is accepted.
- reset_n pulsed low for 2 cycles during WAIT → all outputs 0 immediately, and the stale `fedp_d_val` is ignored. A following request with nslices=1, c=0, a={1,1}, b={1,1} returns d=2.
